microc_uc: RTL

Sequenced control unit for the `microc` single-cycle datapath. It consumes the datapath's `Opcode` and `z` flag and produces the control word that drives it: `s_inc`, `s_inm`, `we3`, `wez` and `Op`, plus a new PC write enable. A run/halt state machine gates execution, detects illegal opcodes and counts retired instructions.

---
 rtl/microc_pkg.sv | 33 +++
 rtl/microc_decoder.sv | 26 ++
 rtl/microc_uc.sv | 85 ++++++++
 3 files changed

// File: rtl/microc_pkg.sv
// microc_pkg: opcodes, ALU ops, FSM states and control word for the microc control unit.
// The STEP state exists only when MICROC_UC_STEP_EN is defined.
package microc_pkg;
    localparam logic [5:0] OPC_LI  = 6'b000100;
    localparam logic [5:0] OPC_J   = 6'b010000;
    localparam logic [5:0] OPC_JZ  = 6'b010001;
    localparam logic [5:0] OPC_JNZ = 6'b010010;

    localparam logic [2:0] ALU_PASS = 3'b000;
    localparam logic [2:0] ALU_NOTA = 3'b001;
    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_SUB  = 3'b011;
    localparam logic [2:0] ALU_AND  = 3'b100;
    localparam logic [2:0] ALU_OR   = 3'b101;
    localparam logic [2:0] ALU_NEGA = 3'b110;
    localparam logic [2:0] ALU_NEGB = 3'b111;

`ifdef MICROC_UC_STEP_EN
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT, S_STEP} uc_state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} uc_state_t;
`endif

    typedef struct packed {
        logic       s_inc;
        logic       s_inm;
        logic       we3;
        logic       wez;
        logic [2:0] op;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '{s_inc: 1'b1, s_inm: 1'b0, we3: 1'b0, wez: 1'b0, op: ALU_PASS};
endpackage

// File: rtl/microc_decoder.sv
// microc_decoder: combinational opcode/z to control word, plus legal-opcode flag.
module microc_decoder
    import microc_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic       z,
    output ctrl_t      ctrl,
    output logic       legal
);
    always_comb begin
        ctrl  = CTRL_IDLE;
        legal = 1'b1;
        if (opcode[5])
            ctrl = '{s_inc: 1'b1, s_inm: 1'b0, we3: 1'b1, wez: 1'b1, op: opcode[4:2]};
        else if (opcode == OPC_LI)
            ctrl = '{s_inc: 1'b1, s_inm: 1'b1, we3: 1'b1, wez: 1'b0, op: ALU_PASS};
        else if (opcode == OPC_J)
            ctrl.s_inc = 1'b0;
        else if (opcode == OPC_JZ)
            ctrl.s_inc = ~z;
        else if (opcode == OPC_JNZ)
            ctrl.s_inc = z;
        else
            legal = 1'b0;
    end
endmodule

// File: rtl/microc_uc.sv
// microc_uc: run/halt sequenced control unit for the microc datapath.
// Define MICROC_UC_STEP_EN to add single-step (step_req/step_ack, STEP state).
module microc_uc
    import microc_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic             z,
    input  logic             start,
    input  logic             halt_req,
`ifdef MICROC_UC_STEP_EN
    input  logic             step_req,
    output logic             step_ack,
`endif
    output logic             s_inc,
    output logic             s_inm,
    output logic             we3,
    output logic             wez,
    output logic [2:0]       op,
    output logic             pc_we,
    output logic             running,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_count
);
    uc_state_t state, nxt;
    ctrl_t     dec, cw;
    logic      legal, exec, go;

    microc_decoder u_dec (.opcode(opcode), .z(z), .ctrl(dec), .legal(legal));

`ifdef MICROC_UC_STEP_EN
    assign exec = (state == S_RUN) || (state == S_STEP);
`else
    assign exec = (state == S_RUN);
`endif
    // reset gating keeps enables low even before the async state clear settles
    assign go      = exec && legal && !reset;
    assign cw      = go ? dec : CTRL_IDLE;
    assign s_inc   = cw.s_inc;
    assign s_inm   = cw.s_inm;
    assign we3     = cw.we3;
    assign wez     = cw.wez;
    assign op      = cw.op;
    assign pc_we   = go;
    assign running = (state == S_RUN);

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE: nxt = (start && !halt_req) ? S_RUN : S_IDLE;
            S_RUN:  nxt = (halt_req || !legal) ? S_HALT : S_RUN;
`ifdef MICROC_UC_STEP_EN
            S_HALT: nxt = halt_req ? S_HALT : start ? S_RUN : step_req ? S_STEP : S_HALT;
            S_STEP: nxt = S_HALT;
`else
            S_HALT: nxt = (start && !halt_req) ? S_RUN : S_HALT;
`endif
            default: nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            illegal     <= 1'b0;
            instr_count <= '0;
        end else begin
            state       <= nxt;
            illegal     <= illegal | (exec && !legal);
            instr_count <= instr_count + CNT_W'(go);
        end
    end

`ifdef MICROC_UC_STEP_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            step_ack <= 1'b0;
        else
            step_ack <= (state == S_STEP);
    end
`endif
endmodule
